// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: computes the result at issue, then holds it for a fixed
// latency before committing it to HI/LO. Optional `MDU_CANCEL_EN adds a flush input.
module mdu_sequencer (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        start,
    input  logic [2:0]  mdu_mod,
    input  logic [31:0] rs_v,
    input  logic [31:0] rt_v,
    input  logic        md_instr_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] stage_hi_q, stage_lo_q;
    logic        commit_q;
    logic [31:0] hi_q, lo_q;

    logic        cancel_w;
    logic        is_div, is_signed, is_arith, div_zero;
    logic [63:0] mul_a, mul_b, prod_d;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo_d, rem_d;
    logic [31:0] res_hi_d, res_lo_d;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    assign is_arith  = (mdu_mod <= 3'd3);
    assign is_div    = (mdu_mod[2:1] == 2'b01);
    assign is_signed = ~mdu_mod[0];
    assign div_zero  = (rt_v == 32'd0);

    // Low 64 bits of a 64x64 product are correct for both signed and unsigned operands.
    assign mul_a  = is_signed ? {{32{rs_v[31]}}, rs_v} : {32'd0, rs_v};
    assign mul_b  = is_signed ? {{32{rt_v[31]}}, rt_v} : {32'd0, rt_v};
    assign prod_d = mul_a * mul_b;

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign a_neg  = is_signed & rs_v[31];
    assign b_neg  = is_signed & rt_v[31];
    assign a_mag  = a_neg ? (~rs_v + 32'd1) : rs_v;
    assign b_mag  = b_neg ? (~rt_v + 32'd1) : rt_v;
    assign b_safe = div_zero ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo_d  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem_d  = a_neg ? (~r_mag + 32'd1) : r_mag;

    assign res_hi_d = is_div ? rem_d : prod_d[63:32];
    assign res_lo_d = is_div ? quo_d : prod_d[31:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            stage_hi_q <= 32'd0;
            stage_lo_q <= 32'd0;
            commit_q   <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!cancel_w) begin
                        if (start && is_arith) begin
                            stage_hi_q <= res_hi_d;
                            stage_lo_q <= res_lo_d;
                            commit_q   <= ~(is_div & div_zero);
                            cnt_q      <= is_div ? 4'd10 : 4'd5;
                            state_q    <= S_BUSY;
                        end else if (mdu_mod == 3'd4) begin
                            hi_q <= rs_v;
                        end else if (mdu_mod == 3'd5) begin
                            lo_q <= rs_v;
                        end
                    end
                end
                S_BUSY: begin
                    if (cancel_w) begin
                        cnt_q   <= 4'd0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            if (commit_q) begin
                                hi_q <= stage_hi_q;
                                lo_q <= stage_lo_q;
                            end
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q == S_BUSY);
    assign stall = md_instr_d & (busy | (start & is_arith));

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized bench for mdu_sequencer against an arithmetic model of HI/LO and latency.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_mod;
    logic [31:0] rs_v, rt_v;
    logic        md_instr_d;
    logic [31:0] hi, lo;
    logic        busy, stall;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_hi, exp_lo;

    mdu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
`ifdef MDU_CANCEL_EN
        .cancel     (cancel),
`endif
        .start      (start),
        .mdu_mod    (mdu_mod),
        .rs_v       (rs_v),
        .rt_v       (rt_v),
        .md_instr_d (md_instr_d),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; divide by zero leaves HI/LO alone.
    task automatic model_op(input logic [2:0] mod, input logic [31:0] a, input logic [31:0] b,
                            inout logic [31:0] h, inout logic [31:0] l);
        longint sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (mod)
            3'd0: begin p = sa * sb; {h, l} = p; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
            3'd2: if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end
            3'd3: if (b != 0) begin l = a / b; h = a % b; end
            default: ;
        endcase
    endtask

    task automatic drive_idle();
        start   = 1'b0;
        mdu_mod = 3'd7;
        rs_v    = $urandom;
        rt_v    = $urandom;
    endtask

    // junk: 0 = quiet while busy, 1 = random start/mod, 2 = forced mtlo attempts
    task automatic run_op(input logic [2:0] mod, input logic [31:0] a, input logic [31:0] b,
                          input logic md, input int junk);
        logic [31:0] nh, nl;
        int lat;
        nh = exp_hi;
        nl = exp_lo;
        model_op(mod, a, b, nh, nl);
        lat = mod[1] ? 10 : 5;
        @(posedge clk); #1;
        start = 1'b1; mdu_mod = mod; rs_v = a; rt_v = b; md_instr_d = md;
        @(negedge clk);
        check("stall_c0", stall, md);
        check("busy_c0", busy, 0);
        @(posedge clk); #1;
        drive_idle();
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check("busy_run", busy, 1);
            check("stall_run", stall, md);
            check("hi_hold", hi, exp_hi);
            check("lo_hold", lo, exp_lo);
            @(posedge clk); #1;
            if (junk == 1 && c < lat) begin
                start = 1'($urandom); mdu_mod = 3'($urandom); rs_v = $urandom;
            end else if (junk == 2 && c < lat) begin
                start = 1'b1; mdu_mod = 3'd5; rs_v = $urandom;
            end else begin
                drive_idle();
            end
        end
        exp_hi = nh;
        exp_lo = nl;
        @(negedge clk);
        check("busy_done", busy, 0);
        check("stall_done", stall, 0);
        check("hi_done", hi, exp_hi);
        check("lo_done", lo, exp_lo);
    endtask

    task automatic move_to(input logic [2:0] mod, input logic [31:0] val);
        @(posedge clk); #1;
        start = 1'($urandom); mdu_mod = mod; rs_v = val; md_instr_d = 1'($urandom);
        @(negedge clk);
        check("mv_busy0", busy, 0);
        check("mv_stall", stall, 0);
        @(posedge clk); #1;
        drive_idle();
        if (mod == 3'd4) exp_hi = val; else exp_lo = val;
        @(negedge clk);
        check("mv_busy1", busy, 0);
        check("mv_hi", hi, exp_hi);
        check("mv_lo", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  m;
        logic [31:0] a, b;
        reset = 1'b1;
        md_instr_d = 1'b0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        drive_idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);

        // Directed cases
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
        check("mulu_hi", hi, 32'h0000_0001);
        check("mulu_lo", lo, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        check("divs_lo", lo, 32'hFFFF_FFFD);
        check("divs_hi", hi, 32'hFFFF_FFFF);
        move_to(3'd4, 32'h1234_5678);
        check("mthi_val", hi, 32'h1234_5678);
        run_op(3'd0, 32'h0000_0003, 32'hFFFF_FFFE, 1'b1, 2);
        check("mul_neg_lo", lo, 32'hFFFF_FFFA);
        check("mul_neg_hi", hi, 32'hFFFF_FFFF);
        move_to(3'd4, 32'hA5A5_A5A5);
        move_to(3'd5, 32'hA5A5_A5A5);
        run_op(3'd3, 32'h1234_5678, 32'd0, 1'b0, 0);
        check("dz_hi", hi, 32'hA5A5_A5A5);
        check("dz_lo", lo, 32'hA5A5_A5A5);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);

        // Reset in cycle 3 of a multiply aborts it
        move_to(3'd4, 32'h0BAD_F00D);
        @(posedge clk); #1;
        start = 1'b1; mdu_mod = 3'd1; rs_v = 32'd7; rt_v = 32'd9;
        @(posedge clk); #1 drive_idle();
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);

`ifdef MDU_CANCEL_EN
        move_to(3'd5, 32'hCAFE_0001);
        @(posedge clk); #1;
        start = 1'b1; mdu_mod = 3'd0; rs_v = 32'd5; rt_v = 32'd6;
        @(posedge clk); #1 drive_idle();
        @(posedge clk); #1;
        @(posedge clk); #1 cancel = 1'b1;
        @(posedge clk); #1 cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", busy, 0);
        check("cancel_hi", hi, exp_hi);
        check("cancel_lo", lo, exp_lo);
`endif

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            m = 3'($urandom_range(0, 5));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            if (m <= 3'd3) run_op(m, a, b, 1'($urandom), 1);
            else           move_to(m, a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
